// File: rtl/lsu_bus_adapter_pkg.sv
// lsu_bus_adapter_pkg: shared FSM state type and RV32I load/store funct3 encodings
package lsu_bus_adapter_pkg;
  typedef enum logic [1:0] {IDLE, REQ, WAIT_RSP, DONE} lsu_state_t;
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
endpackage

// File: rtl/lsu_align.sv
// lsu_align: store lane replication, byte strobes, load extraction/extension and misalignment check
module lsu_align
  import lsu_bus_adapter_pkg::*;
(
  input  logic [1:0]  addr,
  input  logic [2:0]  funct3,
  input  logic        we,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic [3:0]  wstrb,
  output logic [31:0] wlane,
  output logic [31:0] rext,
  output logic        misaligned
);
  logic [15:0] sh;
  // size-dependent lane steering in both directions
  always_comb begin
    sh = 16'(rdata >> {addr, 3'b000});
    wstrb = !we ? 4'b0000 : funct3[1:0] == 2'b00 ? 4'b0001 << addr : funct3[1:0] == 2'b01 ? 4'b0011 << addr : 4'b1111;
    wlane = funct3[1:0] == 2'b00 ? {4{wdata[7:0]}} : funct3[1:0] == 2'b01 ? {2{wdata[15:0]}} : wdata;
    rext = funct3 == F3_B  ? {{24{sh[7]}}, sh[7:0]} :
           funct3 == F3_BU ? {24'b0, sh[7:0]} :
           funct3 == F3_H  ? {{16{sh[15]}}, sh[15:0]} :
           funct3 == F3_HU ? {16'b0, sh[15:0]} : rdata;
    misaligned = (funct3[1:0] == 2'b01 & addr[0]) | (funct3[1:0] == 2'b10 & addr != 2'b00);
  end
endmodule

// File: rtl/lsu_bus_adapter.sv
// lsu_bus_adapter: core load/store port to word-aligned valid/ready bus with stall, fault and timeout
module lsu_bus_adapter
  import lsu_bus_adapter_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 256,
  parameter int CNT_W = 9
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_wdata,
  input  logic        i_read_en,
  input  logic        i_write_en,
  input  logic [2:0]  i_funct3,
  output logic [31:0] o_rdata,
  output logic        o_stall,
  output logic        o_fault,
  output logic        o_bus_req_valid,
  input  logic        i_bus_req_ready,
  output logic [31:0] o_bus_addr,
  output logic        o_bus_we,
  output logic [3:0]  o_bus_wstrb,
  output logic [31:0] o_bus_wdata,
  input  logic        i_bus_rsp_valid,
  input  logic [31:0] i_bus_rsp_rdata,
  input  logic        i_bus_rsp_err
);
  lsu_state_t state, state_n;
  logic [1:0] addr_q;
  logic [2:0] f3_q;
  logic [CNT_W-1:0] cnt;
  logic req, bad, tmo, mis;
  logic [3:0] strb;
  logic [31:0] wlane, rext;
  assign req = i_read_en | i_write_en;
  assign tmo = cnt == CNT_W'(TIMEOUT_CYCLES - 1);
  assign bad = (i_read_en & i_write_en) |
               (i_read_en & (i_funct3 == 3'b011 | i_funct3[2:1] == 2'b11)) |
               (i_write_en & (i_funct3[2] | i_funct3[1:0] == 2'b11)) | mis;
  lsu_align u_align (
    .addr       (state == IDLE ? i_addr[1:0] : addr_q),
    .funct3     (state == IDLE ? i_funct3 : f3_q),
    .we         (i_write_en),
    .wdata      (i_wdata),
    .rdata      (i_bus_rsp_rdata),
    .wstrb      (strb),
    .wlane      (wlane),
    .rext       (rext),
    .misaligned (mis)
  );
  // state register
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_n;
  // next state and stall; timeout wins over a same-cycle accept
  always_comb begin
    state_n = state;
    o_stall = 1'b1;
    case (state)
      IDLE: begin
        o_stall = req;
        state_n = !req ? IDLE : bad ? DONE : REQ;
      end
      REQ: state_n = tmo ? DONE : i_bus_req_ready ? WAIT_RSP : REQ;
      WAIT_RSP: state_n = (i_bus_rsp_valid | tmo) ? DONE : WAIT_RSP;
      DONE: begin
        o_stall = 1'b0;
        state_n = IDLE;
      end
    endcase
  end
  // latched request, bus fields, timeout counter and result registers
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      addr_q <= '0;
      f3_q <= '0;
      cnt <= '0;
      o_bus_req_valid <= 1'b0;
      o_bus_addr <= '0;
      o_bus_we <= 1'b0;
      o_bus_wstrb <= '0;
      o_bus_wdata <= '0;
      o_fault <= 1'b0;
      o_rdata <= '0;
    end else case (state)
      IDLE: if (req) begin
        addr_q <= i_addr[1:0];
        f3_q <= i_funct3;
        cnt <= '0;
        o_bus_req_valid <= !bad;
        o_bus_addr <= {i_addr[31:2], 2'b00};
        o_bus_we <= i_write_en;
        o_bus_wstrb <= strb;
        o_bus_wdata <= wlane;
        o_fault <= bad;
        if (bad) o_rdata <= '0;
      end
      REQ, WAIT_RSP: begin
        cnt <= cnt + 1'b1;
        if (tmo | (state == REQ & i_bus_req_ready)) o_bus_req_valid <= 1'b0;
        if (state == WAIT_RSP & i_bus_rsp_valid) begin
          o_fault <= i_bus_rsp_err;
          o_rdata <= (i_bus_rsp_err | o_bus_we) ? '0 : rext;
        end else if (tmo) begin
          o_fault <= 1'b1;
          o_rdata <= '0;
        end
      end
      DONE: o_fault <= 1'b0;
    endcase
endmodule

// File: tb/tb_lsu_bus_adapter.sv
// tb_lsu_bus_adapter: directed vectors against hand-computed results
module tb_lsu_bus_adapter;
  logic clk = 1'b0, rst = 1'b1;
  logic [31:0] i_addr = '0, i_wdata = '0, o_rdata, o_bus_addr, o_bus_wdata, i_bus_rsp_rdata = '0;
  logic i_read_en = 1'b0, i_write_en = 1'b0, o_stall, o_fault, o_bus_req_valid, o_bus_we;
  logic i_bus_req_ready = 1'b0, i_bus_rsp_valid = 1'b0, i_bus_rsp_err = 1'b0;
  logic [2:0] i_funct3 = '0;
  logic [3:0] o_bus_wstrb;
  int errors = 0, checks = 0;
  int sn, rn;
  logic [31:0] rd;
  logic flt;

  lsu_bus_adapter #(.TIMEOUT_CYCLES(8), .CNT_W(4)) dut (
    .clk(clk), .rst(rst), .i_addr(i_addr), .i_wdata(i_wdata), .i_read_en(i_read_en),
    .i_write_en(i_write_en), .i_funct3(i_funct3), .o_rdata(o_rdata), .o_stall(o_stall),
    .o_fault(o_fault), .o_bus_req_valid(o_bus_req_valid), .i_bus_req_ready(i_bus_req_ready),
    .o_bus_addr(o_bus_addr), .o_bus_we(o_bus_we), .o_bus_wstrb(o_bus_wstrb),
    .o_bus_wdata(o_bus_wdata), .i_bus_rsp_valid(i_bus_rsp_valid),
    .i_bus_rsp_rdata(i_bus_rsp_rdata), .i_bus_rsp_err(i_bus_rsp_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // drives one access, answers the bus, checks bus fields on every request cycle
  task automatic access(input logic r, input logic w, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] wd, input logic [31:0] rsp, input logic err, input int dly,
                        input logic resp, input logic [31:0] ea, input logic [3:0] es, input logic [31:0] ew);
    logic pend = 1'b0, done = 1'b0;
    sn = 0;
    rn = 0;
    i_read_en = r; i_write_en = w; i_funct3 = f3; i_addr = a; i_wdata = wd;
    #1;
    for (int c = 0; c < 40 && !done; c++) begin
      i_bus_rsp_valid = pend & resp;
      i_bus_rsp_err = err;
      i_bus_rsp_rdata = rsp;
      pend = 1'b0;
      if (o_stall) sn++;
      else begin
        done = 1'b1;
        rd = o_rdata;
        flt = o_fault;
        chk("done_reqv", {31'b0, o_bus_req_valid}, 32'd0);
      end
      if (o_bus_req_valid) begin
        rn++;
        chk("bus_addr", o_bus_addr, ea);
        chk("bus_wstrb", {28'b0, o_bus_wstrb}, {28'b0, es});
        chk("bus_we", {31'b0, o_bus_we}, {31'b0, w});
        if (w) chk("bus_wdata", o_bus_wdata, ew);
        i_bus_req_ready = rn > dly;
        pend = i_bus_req_ready;
      end else i_bus_req_ready = 1'b0;
      if (!done) tick;
    end
    if (!done) chk("done_bound", 32'd0, 32'd1);
    i_read_en = 1'b0; i_write_en = 1'b0; i_bus_rsp_valid = 1'b0; i_bus_req_ready = 1'b0;
    tick;
    chk("fault_pulse", {31'b0, o_fault}, 32'd0);
  endtask

  task automatic result(input string tag, input int es, input int er, input logic [31:0] erd, input logic ef);
    chk({tag, "_stall"}, sn, es);
    chk({tag, "_reqs"}, rn, er);
    chk({tag, "_rdata"}, rd, erd);
    chk({tag, "_fault"}, {31'b0, flt}, {31'b0, ef});
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_reqv", {31'b0, o_bus_req_valid}, 32'd0);
    chk("rst_rdata", o_rdata, 32'd0);
    chk("rst_fault", {31'b0, o_fault}, 32'd0);
    chk("rst_addr", o_bus_addr, 32'd0);
    chk("rst_stall", {31'b0, o_stall}, 32'd0);
    rst = 1'b0;
    tick;
    access(1, 0, 3'b010, 32'h100, 0, 32'hDEADBEEF, 0, 0, 1, 32'h100, 4'b0000, 0);
    result("lw", 3, 1, 32'hDEADBEEF, 0);
    access(1, 0, 3'b000, 32'h103, 0, 32'h80123456, 0, 0, 1, 32'h100, 4'b0000, 0);
    result("lb", 3, 1, 32'hFFFFFF80, 0);
    access(1, 0, 3'b100, 32'h103, 0, 32'h80123456, 0, 0, 1, 32'h100, 4'b0000, 0);
    result("lbu", 3, 1, 32'h00000080, 0);
    access(1, 0, 3'b101, 32'h102, 0, 32'h80123456, 0, 0, 1, 32'h100, 4'b0000, 0);
    result("lhu", 3, 1, 32'h00008012, 0);
    access(1, 0, 3'b001, 32'h102, 0, 32'h80123456, 0, 0, 1, 32'h100, 4'b0000, 0);
    result("lh", 3, 1, 32'hFFFF8012, 0);
    access(0, 1, 3'b001, 32'h206, 32'h0000ABCD, 0, 0, 5, 1, 32'h204, 4'b1100, 32'hABCDABCD);
    result("sh", 8, 6, 32'h0, 0);
    access(0, 1, 3'b000, 32'h201, 32'h12345678, 0, 0, 0, 1, 32'h200, 4'b0010, 32'h78787878);
    result("sb", 3, 1, 32'h0, 0);
    access(1, 0, 3'b010, 32'h100, 0, 32'h5A5A5A5A, 0, 0, 1, 32'h100, 4'b0000, 0);
    access(1, 0, 3'b010, 32'h102, 0, 0, 0, 0, 1, 0, 0, 0);
    result("lw_mis", 1, 0, 32'h0, 1);
    access(1, 0, 3'b001, 32'h101, 0, 0, 0, 0, 1, 0, 0, 0);
    result("lh_mis", 1, 0, 32'h0, 1);
    access(0, 1, 3'b011, 32'h200, 32'h1, 0, 0, 0, 1, 0, 0, 0);
    result("sw_ill", 1, 0, 32'h0, 1);
    access(1, 1, 3'b010, 32'h200, 32'h1, 0, 0, 0, 1, 0, 0, 0);
    result("rdwr_ill", 1, 0, 32'h0, 1);
    access(1, 0, 3'b010, 32'h300, 0, 0, 0, 0, 0, 32'h300, 4'b0000, 0);
    result("tmo_rsp", 9, 1, 32'h0, 1);
    access(1, 0, 3'b010, 32'h300, 0, 0, 0, 100, 0, 32'h300, 4'b0000, 0);
    result("tmo_req", 9, 8, 32'h0, 1);
    access(1, 0, 3'b010, 32'h104, 0, 32'h11223344, 0, 0, 1, 32'h104, 4'b0000, 0);
    result("b2b_lw", 3, 1, 32'h11223344, 0);
    access(0, 1, 3'b010, 32'h108, 32'hCAFEF00D, 32'hFFFFFFFF, 1, 0, 1, 32'h108, 4'b1111, 32'hCAFEF00D);
    result("b2b_sw_err", 3, 1, 32'h0, 1);
    access(1, 0, 3'b010, 32'h10C, 0, 32'h55AA55AA, 0, 0, 1, 32'h10C, 4'b0000, 0);
    result("pre_rst", 3, 1, 32'h55AA55AA, 0);
    i_read_en = 1'b1; i_funct3 = 3'b010; i_addr = 32'h110; i_bus_req_ready = 1'b1;
    tick;
    chk("mid_reqv", {31'b0, o_bus_req_valid}, 32'd1);
    tick;
    chk("mid_wait_stall", {31'b0, o_stall}, 32'd1);
    i_read_en = 1'b0; i_bus_req_ready = 1'b0;
    rst = 1'b1;
    #1;
    chk("mid_rst_stall", {31'b0, o_stall}, 32'd0);
    chk("mid_rst_rdata", o_rdata, 32'd0);
    chk("mid_rst_reqv", {31'b0, o_bus_req_valid}, 32'd0);
    tick;
    rst = 1'b0;
    i_bus_rsp_valid = 1'b1; i_bus_rsp_rdata = 32'hFFFFFFFF;
    tick;
    i_bus_rsp_valid = 1'b0;
    tick;
    chk("late_rsp_rdata", o_rdata, 32'd0);
    chk("late_rsp_fault", {31'b0, o_fault}, 32'd0);
    chk("late_rsp_stall", {31'b0, o_stall}, 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/lsu_bus_adapter.md
Name: lsu_bus_adapter

Overview:
- Sits directly downstream of the core's load/store stage, between the core data-memory port and a valid/ready data bus with variable latency.
- Converts core byte/half/word accesses into word-aligned bus transactions with byte strobes.
- Aligns and sign/zero-extends load data.
- Holds the pipeline via a stall output while a transaction is outstanding.
- Reports misaligned, illegal, error and timeout accesses as a single fault pulse.

Parameters:
- TIMEOUT_CYCLES, 256: bus cycles allowed in REQ+WAIT_RSP before the access is aborted with a fault.
- CNT_W, 9: width of the timeout counter; must be at least clog2(TIMEOUT_CYCLES+1).

Ports:
- clk  in  1  core clock
- rst  in  1  asynchronous reset, active-high
- i_addr  in  32  byte address from core (ALU result)
- i_wdata  in  32  store data (rs2 value, unshifted)
- i_read_en  in  1  load request
- i_write_en  in  1  store request
- i_funct3  in  3  access size/sign (RV32I load/store encoding)
- o_rdata  out  32  extended load result, valid in DONE
- o_stall  out  1  hold core pipeline
- o_fault  out  1  one-cycle fault pulse in DONE
- o_bus_req_valid  out  1  bus request valid
- i_bus_req_ready  in  1  bus accepts request
- o_bus_addr  out  32  word address ({addr[31:2],2'b00})
- o_bus_we  out  1  1=write
- o_bus_wstrb  out  4  byte strobes (0000 on reads)
- o_bus_wdata  out  32  lane-replicated store data
- i_bus_rsp_valid  in  1  response valid
- i_bus_rsp_rdata  in  32  response word
- i_bus_rsp_err  in  1  bus error, qualified by rsp_valid

Behaviour:
- Reset: state=IDLE; all registered outputs 0 (o_rdata, o_fault, o_bus_*, counter).
- Core contract: core holds i_* stable while o_stall=1.
- FSM states: IDLE, REQ, WAIT_RSP, DONE.
- IDLE:
  - o_stall = i_read_en | i_write_en (combinational).
  - On a request, latch addr/funct3/we/wdata and compute fault checks.
  - Legal request -> REQ.
  - Fault -> DONE with fault flag; no bus activity.
- Fault checks:
  - read_en & write_en both set.
  - Load funct3 not in {000,001,010,100,101}.
  - Store funct3 not in {000,001,010}.
  - Half access with addr[0]=1.
  - Word access with addr[1:0]!=0.
- REQ:
  - o_bus_req_valid=1; address/we/wstrb/wdata stable until accepted.
  - On ready -> WAIT_RSP.
- WAIT_RSP:
  - On rsp_valid -> DONE; capture the extended rdata (loads only).
  - rsp_err=1 sets the fault flag and forces rdata=0.
  - The bus never responds in the same cycle it accepts; the adapter ignores rsp_valid outside WAIT_RSP.
- Timeout:
  - Counter clears on IDLE->REQ and increments each cycle in REQ/WAIT_RSP.
  - Reaching TIMEOUT_CYCLES -> DONE with fault, rdata=0, req_valid dropped.
- DONE:
  - o_stall=0; o_fault=flag; o_rdata holds the result.
  - Exactly one cycle, then IDLE.
  - A new request is seen in the following IDLE cycle, so the same request is never reissued.
- Minimum latency (ready=1, response one cycle after accept): stall high 3 cycles (IDLE, REQ, WAIT_RSP), DONE on the 4th cycle.
- Store lanes:
  - SB: wstrb = 0001<<addr[1:0], wdata = {4{wdata[7:0]}}.
  - SH: wstrb = 0011<<addr[1:0], wdata = {2{wdata[15:0]}}.
  - SW: wstrb = 1111.
- Load extraction:
  - Byte = rdata >> (8*addr[1:0]); half = rdata >> (8*addr[1:0]) with addr[0]=0.
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes through.
- Reset mid-transaction returns to IDLE immediately and drops req_valid. The bus tolerates an abandoned request; a late response is ignored.

Decomposition:
- Shared core package contents:
  - lsu_state_t enum.
  - funct3 constants F3_B/F3_H/F3_W/F3_BU/F3_HU.
- One natural combinational sub-module: lsu_align, which performs store lane replication, strobe generation, load extraction/extension and the misalignment check.
- FSM and timeout counter stay in lsu_bus_adapter.

Test Plan:
- LW addr 0x100: ready=1, rsp one cycle after accept with rdata 0xDEADBEEF -> bus_addr 0x100, wstrb 0000; stall 3 cycles; o_rdata=0xDEADBEEF in DONE; fault=0.
- LB addr 0x103 and LBU addr 0x103, rdata 0x80123456 -> o_rdata 0xFFFFFF80 and 0x00000080 respectively.
- SH addr 0x206, wdata 0x0000ABCD, ready held low 5 cycles -> req_valid held 5+1 cycles with stable fields; wstrb 1100, wdata 0xABCDABCD, bus_addr 0x204.
- LW addr 0x102 -> no req_valid; stall 1 cycle; DONE with o_fault=1, o_rdata=0. Same for SW with funct3=011.
- TIMEOUT_CYCLES=8, ready=1, no response -> DONE 8 cycles after entering REQ; fault=1; req_valid low.
- Back-to-back LW then SW, plus rsp_err on the SW -> two distinct bus requests, second DONE with fault=1. Assert rst during WAIT_RSP -> outputs zero immediately; a later rsp_valid is ignored.
